// File: rtl/muldiv_ctrl_if.sv
// Request/result bus between the control unit and the MUL/DIV sequencer.
// The control unit drives start/op/a/b and reads busy/done and the HI/LO results.
interface muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// MUL/DIV sequencer owning HI/LO: multicycle MUL32 capture, signed restoring divide.
// Optional MULDIV_DIVZERO_FLAG_EN adds a div_zero pulse output alongside done.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic         clk,
  input  logic         clr,
  muldiv_ctrl_if.slave bus,
  output logic [31:0]  mul_a,
  output logic [31:0]  mul_b,
  input  logic [63:0]  mul_p
`ifdef MULDIV_DIVZERO_FLAG_EN
  ,
  output logic         div_zero
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    MUL_WAIT,
    DIV_RUN,
    DIV_FIX,
    DONE
  } state_t;

  localparam logic [31:0] MUL_LAST = 32'(MUL_CYCLES - 1);
  localparam logic [31:0] DIV_LAST = 32'd31;

  state_t      state;
  state_t      nxt;
  logic [31:0] cnt;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic        neg_q;
  logic        neg_r;
  logic        dz;

  logic        ready;
  logic        acc_mul;
  logic        acc_div;
  logic        b_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] part;
  logic [31:0] diff;
  logic        ge;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // DONE behaves like IDLE for acceptance so ops can issue back-to-back
  assign ready   = (state == IDLE) || (state == DONE);
  assign acc_mul = ready && bus.start && (bus.op == 2'b00);
  assign acc_div = ready && bus.start && (bus.op == 2'b01);
  assign b_zero  = (bus.b == 32'd0);
  assign a_mag   = bus.a[31] ? 32'd0 - bus.a : bus.a;
  assign b_mag   = bus.b[31] ? 32'd0 - bus.b : bus.b;

  // One restoring step; part may exceed 32 bits only transiently
  assign part  = {rem, dvd[31]};
  assign diff  = part[31:0] - dvs;
  assign ge    = part[32] || (part[31:0] >= dvs);
  assign q_fix = neg_q ? 32'd0 - dvd : dvd;
  assign r_fix = neg_r ? 32'd0 - rem : rem;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: begin
        nxt = IDLE;
        unique case (1'b1)
          acc_mul: nxt = MUL_WAIT;
          acc_div: nxt = b_zero ? DIV_FIX : DIV_RUN;
          default: nxt = IDLE;
        endcase
      end
      MUL_WAIT: if (cnt == MUL_LAST) nxt = DONE;
      DIV_RUN:  if (cnt == DIV_LAST) nxt = DIV_FIX;
      DIV_FIX:  nxt = DONE;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      MUL_WAIT, DIV_RUN, DIV_FIX: bus.busy = 1'b1;
      DONE:                       bus.done = 1'b1;
      default:                    bus.busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt    <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      bus.hi <= '0;
      bus.lo <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          cnt <= '0;
          unique case (1'b1)
            acc_mul: begin
              mul_a <= bus.a;
              mul_b <= bus.b;
            end
            acc_div: begin
              dz    <= b_zero;
              neg_q <= bus.a[31] ^ bus.b[31];
              neg_r <= bus.a[31];
              dvd   <= b_zero ? bus.a : a_mag;
              dvs   <= b_mag;
              rem   <= '0;
            end
            default: ;
          endcase
        end
        MUL_WAIT: begin
          cnt <= cnt + 32'd1;
          if (cnt == MUL_LAST) {bus.hi, bus.lo} <= mul_p;
        end
        DIV_RUN: begin
          cnt <= cnt + 32'd1;
          rem <= ge ? diff : part[31:0];
          dvd <= {dvd[30:0], ge};
        end
        DIV_FIX: begin
          if (dz) begin
            bus.hi <= dvd;
            bus.lo <= 32'hFFFF_FFFF;
          end else begin
            bus.hi <= r_fix;
            bus.lo <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIVZERO_FLAG_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) div_zero <= 1'b0;
    else     div_zero <= (state == DIV_FIX) && dz;
  end
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised self-checking bench for muldiv_ctrl against an arithmetic model.
// Build with MULDIV_DIVZERO_FLAG_EN to also check the div_zero pulse.
module tb_muldiv_ctrl;
  localparam int MC = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_p;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic        div_zero;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] last = '0;
  logic [31:0] sp [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF,
                          32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk   (clk),
    .clr   (clr),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p)
`ifdef MULDIV_DIVZERO_FLAG_EN
    ,
    .div_zero (div_zero)
`endif
  );

  assign mul_p = $signed({{32{mul_a[31]}}, mul_a}) *
                 $signed({{32{mul_b[31]}}, mul_b});

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint p;
    int q;
    int r;
    if (op == 2'b00) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {32'h0, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [31:0] b);
    if (op == 2'b00) return MC;
    return (b == 32'd0) ? 1 : 33;
  endfunction

  task automatic go(input logic [1:0] op, input logic [31:0] a,
                    input logic [31:0] b, input bit noise);
    logic [63:0] exp;
    int lat;
    int k;
    bit got;
    exp = model(op, a, b);
    lat = latency(op, b);
    got = 1'b0;
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 2'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
    check("busy_after_start", bus.busy, 1);
    for (k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (op == 2'b00) begin
        check("mul_a_hold", mul_a, a);
        check("mul_b_hold", mul_b, b);
      end
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      check("busy_mid", bus.busy, 1);
      if (noise && k == 1) begin
        bus.start = 1'b1;
        bus.op = 2'($urandom_range(0, 1));
        bus.a = $urandom;
        bus.b = $urandom;
      end
    end
    check("done_seen", got, 1);
    if (got) begin
      check("latency", k, lat);
      check("result", {bus.hi, bus.lo}, exp);
      check("busy_at_done", bus.busy, 0);
`ifdef MULDIV_DIVZERO_FLAG_EN
      check("div_zero", div_zero, (op == 2'b01) && (b == 32'd0));
`endif
      last = exp;
    end
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.a = $urandom;
      bus.b = $urandom;
      check("idle_done", bus.done, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_hold", {bus.hi, bus.lo}, last);
    end
  endtask

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
    check("rst_mul_a", mul_a, 32'h0);
    check("rst_mul_b", mul_b, 32'h0);
`ifdef MULDIV_DIVZERO_FLAG_EN
    check("rst_div_zero", div_zero, 0);
`endif
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;

    go(2'b00, 32'h8000_0000, 32'h0000_0002, 1'b0);
    check("t1_value", {bus.hi, bus.lo}, 64'hFFFF_FFFF_0000_0000);
    idle(1);

    go(2'b00, 32'h8000_0000, 32'h7FFF_FFFE, 1'b0);
    check("t2_value", {bus.hi, bus.lo}, 64'hC000_0001_0000_0000);
    go(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("t2_b2b", {bus.hi, bus.lo}, 64'h0000_0000_0000_0001);
    idle(1);

    go(2'b01, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    check("t3_neg_div", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    go(2'b01, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
    check("t3_pos_div", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFD);
    idle(2);

    go(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("t4_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    go(2'b01, 32'h0000_0005, 32'h0000_0000, 1'b0);
    check("t4_dz", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
    idle(1);

    for (int i = 0; i < 2; i++) begin
      bus.start = 1'b1;
      bus.op = (i == 0) ? 2'b10 : 2'b11;
      bus.a = $urandom;
      bus.b = $urandom;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("rsv_busy", bus.busy, 0);
      check("rsv_done", bus.done, 0);
      idle(2);
    end

    go(2'b00, 32'd1234, 32'd5678, 1'b1);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      go(2'($urandom_range(0, 1)), pick(), pick(), 1'($urandom));
      idle($urandom_range(0, 2));
    end

    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.a = 32'h1234_5678;
    bus.b = 32'h0000_0013;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    check("t6_busy", bus.busy, 0);
    check("t6_done", bus.done, 0);
    check("t6_hilo", {bus.hi, bus.lo}, 64'h0);
    check("t6_mul_a", mul_a, 32'h0);
    check("t6_mul_b", mul_b, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      check("t6_no_done", bus.done, 0);
    end
    @(negedge clk);
    clr = 1'b0;
    last = '0;
    go(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
